// File: rtl/uart_rx_fifo_if.sv
// Handshake bundle between uart_rx and the receive FIFO consumer.
// slave: FIFO side; master: producer/consumer side.
interface uart_rx_fifo_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_break;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_break;

  modport master (
    output in_valid,
    output in_data,
    output in_break,
    output out_ready,
    input  out_valid,
    input  out_data,
    input  out_break
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_break,
    input  out_ready,
    output out_valid,
    output out_data,
    output out_break
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// FWFT byte/BREAK buffer behind uart_rx with level and sticky overflow.
// Optional almost_full output: define UART_RX_FIFO_ALMOST_FULL_EN.
module uart_rx_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              resetn,
  uart_rx_fifo_if.slave     bus,
  output logic [ADDR_W:0]   level,
  output logic              overflow,
  input  logic              clear_overflow,
`ifdef UART_RX_FIFO_ALMOST_FULL_EN
  output logic              almost_full,
`endif
  input  logic              flush
);

  localparam logic [ADDR_W:0] LP_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LP_AF   = (ADDR_W+1)'(DEPTH - 2);

  logic [8:0]        r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wptr;
  logic [ADDR_W-1:0] r_rptr;
  logic [ADDR_W:0]   r_level;
  logic              r_ovf;

  logic              w_full;
  logic              w_nempty;
  logic              w_pop;
  logic              w_push;
  logic              w_drop;
  logic [8:0]        w_entry;
  logic [8:0]        w_head;
  logic [ADDR_W:0]   w_level_nxt;

  assign w_full   = (r_level == LP_FULL);
  assign w_nempty = (r_level != '0);
  assign w_pop    = w_nempty && bus.out_ready && !flush;
  assign w_push   = bus.in_valid && !flush && (!w_full || w_pop);
  assign w_drop   = bus.in_valid && !flush && w_full && !w_pop;
  assign w_entry  = bus.in_break ? 9'h100 : {1'b0, bus.in_data};

  always_comb begin
    w_level_nxt = r_level;
    if (w_push && !w_pop)
      w_level_nxt = r_level + 1'b1;
    else if (w_pop && !w_push)
      w_level_nxt = r_level - 1'b1;
  end

  // Storage needs no reset; head is masked to zero while empty.
  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wptr] <= w_entry;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push)
        r_wptr <= r_wptr + 1'b1;
      if (w_pop)
        r_rptr <= r_rptr + 1'b1;
      r_level <= w_level_nxt;
    end
  end

  // A drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      r_ovf <= 1'b0;
    else if (w_drop)
      r_ovf <= 1'b1;
    else if (clear_overflow)
      r_ovf <= 1'b0;
  end

`ifdef UART_RX_FIFO_ALMOST_FULL_EN
  logic r_af;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      r_af <= 1'b0;
    else if (flush)
      r_af <= 1'b0;
    else
      r_af <= (w_level_nxt >= LP_AF);
  end

  assign almost_full = r_af;
`endif

  assign w_head        = w_nempty ? r_mem[r_rptr] : 9'h000;
  assign bus.out_valid = w_nempty;
  assign bus.out_data  = w_head[7:0];
  assign bus.out_break = w_head[8];
  assign level         = r_level;
  assign overflow      = r_ovf;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: stimulus queues expected entries,
// a negedge monitor pops and compares on every accepted head entry.
module tb_uart_rx_fifo;

  logic       clk;
  logic       resetn;
  logic [4:0] level;
  logic       overflow;
  logic       clear_overflow;
  logic       flush;
`ifdef UART_RX_FIFO_ALMOST_FULL_EN
  logic       almost_full;
`endif

  uart_rx_fifo_if bus ();

  uart_rx_fifo #(.DEPTH(16), .ADDR_W(4)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .bus            (bus),
    .level          (level),
    .overflow       (overflow),
    .clear_overflow (clear_overflow),
`ifdef UART_RX_FIFO_ALMOST_FULL_EN
    .almost_full    (almost_full),
`endif
    .flush          (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_chk  = 0;
  int         n_pass = 0;
  logic [8:0] exp_q[$];
  int         m_level = 0;
  bit         m_ov    = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp)
      n_pass++;
    else
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  always @(negedge clk) begin
    if (resetn && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL pop_unexpected: got %0h expected none",
                 {bus.out_break, bus.out_data});
      end else begin
        chk("pop_entry", int'({bus.out_break, bus.out_data}),
            int'(exp_q.pop_front()));
      end
    end
  end

  task automatic step(input bit iv, input logic [7:0] d,
                      input bit b, input bit rdy,
                      input bit fl = 0, input bit clr = 0);
    bit pop;
    bit push;
    bus.in_valid   = iv;
    bus.in_data    = d;
    bus.in_break   = b;
    bus.out_ready  = rdy;
    flush          = fl;
    clear_overflow = clr;
    pop  = rdy && (m_level > 0) && !fl;
    push = iv && !fl && ((m_level < 16) || pop);
    if (fl) begin
      exp_q.delete();
      m_level = 0;
    end else begin
      if (push)
        exp_q.push_back(b ? 9'h100 : {1'b0, d});
      m_level = m_level + int'(push) - int'(pop);
    end
    if (iv && !fl && !push)
      m_ov = 1;
    else if (clr)
      m_ov = 0;
    @(posedge clk);
    #1;
    bus.in_valid   = 0;
    bus.in_break   = 0;
    bus.out_ready  = 0;
    flush          = 0;
    clear_overflow = 0;
    chk("level", int'(level), m_level);
    chk("overflow", int'(overflow), int'(m_ov));
    chk("out_valid", int'(bus.out_valid), int'(m_level != 0));
`ifdef UART_RX_FIFO_ALMOST_FULL_EN
    chk("almost_full", int'(almost_full), int'(m_level >= 14));
`endif
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && m_level > 0; i++)
      step(0, 8'h00, 0, 1);
    chk("drain_q_empty", exp_q.size(), 0);
  endtask

  initial begin
    resetn         = 0;
    bus.in_valid   = 0;
    bus.in_data    = 8'h00;
    bus.in_break   = 0;
    bus.out_ready  = 0;
    flush          = 0;
    clear_overflow = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_level", int'(level), 0);
    chk("rst_valid", int'(bus.out_valid), 0);
    chk("rst_data", int'(bus.out_data), 0);
    chk("rst_break", int'(bus.out_break), 0);
    chk("rst_ovf", int'(overflow), 0);
    resetn = 1;

    // 1: single byte, held head, then pop
    step(1, 8'hA5, 0, 0);
    for (int i = 0; i < 5; i++) begin
      chk("hold_data", int'(bus.out_data), 8'hA5);
      chk("hold_break", int'(bus.out_break), 0);
      chk("hold_valid", int'(bus.out_valid), 1);
      @(posedge clk);
      #1;
    end
    step(0, 8'h00, 0, 1);
    chk("t1_empty", int'(bus.out_valid), 0);

    // 2: fill, overflow drop, drain, clear
    for (int i = 1; i <= 16; i++)
      step(1, 8'(i), 0, 0);
    chk("t2_full", int'(level), 16);
    chk("t2_noovf", int'(overflow), 0);
    step(1, 8'h11, 0, 0);
    chk("t2_ovf", int'(overflow), 1);
    drain();
    step(0, 8'h00, 0, 0, 0, 1);
    chk("t2_clr", int'(overflow), 0);

    // 3: push and pop together while full
    for (int i = 0; i < 16; i++)
      step(1, 8'(8'h20 + i), 0, 0);
    step(1, 8'h77, 0, 1);
    chk("t3_level", int'(level), 16);
    chk("t3_noovf", int'(overflow), 0);
    drain();

    // 4: BREAK entry masks data
    step(1, 8'h3C, 1, 0);
    chk("t4_brk", int'(bus.out_break), 1);
    chk("t4_brk_data", int'(bus.out_data), 0);
    step(1, 8'h3C, 0, 1);
    chk("t4_data", int'(bus.out_data), 8'h3C);
    chk("t4_nobrk", int'(bus.out_break), 0);
    drain();

    // 5: flush beats push; then pointer wrap
    for (int i = 0; i < 3; i++)
      step(1, 8'(8'h40 + i), 0, 0);
    step(1, 8'h55, 0, 0, 1);
    chk("t5_flush_lvl", int'(level), 0);
    chk("t5_flush_ovf", int'(overflow), 0);
    step(1, 8'h66, 0, 0);
    chk("t5_66", int'(bus.out_data), 8'h66);
    for (int i = 0; i < 40; i++)
      step(1, 8'(8'h80 + i), 0, 1);
    drain();

    // 6: async reset mid-stream with overflow set
    for (int i = 0; i < 16; i++)
      step(1, 8'(8'hC0 + i), 0, 0);
    step(1, 8'hEE, 0, 0);
    for (int i = 0; i < 11; i++)
      step(0, 8'h00, 0, 1);
    chk("t6_lvl5", int'(level), 5);
    chk("t6_ovf1", int'(overflow), 1);
    #2;
    resetn = 0;
    #1;
    chk("t6_rst_level", int'(level), 0);
    chk("t6_rst_valid", int'(bus.out_valid), 0);
    chk("t6_rst_data", int'(bus.out_data), 0);
    chk("t6_rst_ovf", int'(overflow), 0);
`ifdef UART_RX_FIFO_ALMOST_FULL_EN
    chk("t6_rst_af", int'(almost_full), 0);
`endif
    exp_q.delete();
    m_level = 0;
    m_ov    = 0;
    @(posedge clk);
    #1;
    resetn = 1;
    step(1, 8'h99, 0, 0);
    chk("t6_after", int'(bus.out_data), 8'h99);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive-side byte buffer that sits directly downstream of uart_rx. It captures every single-cycle received byte and BREAK event, and presents them to the system through a first-word-fall-through valid/ready interface. uart_rx has no backpressure, so this block absorbs bursts. It reports fill level and records overflow with a sticky flag.

Parameters:
DEPTH, 16, number of entries; power of two, minimum 2
ADDR_W, 4, pointer width; must equal log2(DEPTH); level uses ADDR_W+1 bits

Ports:
clk  input  1  system clock; all logic on the rising edge
resetn  input  1  asynchronous, active-low reset
in_valid  input  1  single-cycle pulse from uart_rx_valid
in_data  input  8  byte from uart_rx_data; sampled when in_valid=1
in_break  input  1  from uart_rx_break; sampled when in_valid=1
out_valid  output  1  head entry available
out_ready  input  1  consumer accepts head entry when out_valid=1
out_data  output  8  head entry data
out_break  output  1  head entry is a BREAK marker
level  output  ADDR_W+1  number of stored entries, 0..DEPTH
overflow  output  1  sticky flag: a push was dropped because the FIFO was full
clear_overflow  input  1  one-cycle pulse that clears overflow
flush  input  1  one-cycle pulse that discards all entries

Behaviour:
- Reset (resetn=0, asynchronous): pointers=0, level=0, out_valid=0, out_data=8'h00, out_break=0, overflow=0. Storage contents are don't-care.
- Entry format: 9 bits, {break, data}.
  - Push of an entry happens when in_valid=1, is not blocked by full, and flush=0.
  - When in_break=1, the stored entry is {1, 8'h00} regardless of in_data.
- Pop happens when out_valid && out_ready.
- Latency: a push into an empty FIFO at edge N gives out_valid=1 and out_data valid after edge N, i.e. in cycle N+1. No combinational path from in_* to out_*.
- Head output: out_data and out_break show the entry at the read pointer. They are registered or read from registered storage, and must stay stable while out_valid=1 and out_ready=0.
- level: registered.
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on push and pop in the same cycle.
  - out_valid = (level != 0).
- Full (level=DEPTH):
  - in_valid with a pop in the same cycle: the push is accepted and level stays at DEPTH.
  - in_valid without a pop: the byte is dropped and overflow is set. Stored data is untouched.
- Empty (level=0): out_ready is ignored. A push and out_ready in the same cycle does not pop, because out_valid was 0 that cycle.
- Pointers: ADDR_W-bit counters that wrap from DEPTH−1 to 0 naturally.
- flush: has priority over push and pop in the same cycle.
  - Sets pointers=0, level=0 and out_valid=0 at the next edge.
  - An in_valid in the same cycle is discarded and does not set overflow.
  - overflow is unaffected by flush.
- overflow: if a set and clear_overflow occur in the same cycle, set wins and overflow stays 1.
- Reset mid-operation: all state returns to reset values immediately. No partial entry survives.

Optional Feature:
Macro UART_RX_FIFO_ALMOST_FULL_EN.
- Defined: adds output almost_full (1 bit), registered.
  - Asserted when level >= DEPTH−2 after the edge, otherwise 0.
  - Reset value 0.
  - Cleared by flush.
- Not defined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
1. Reset, then push 8'hA5 with out_ready=0 -> in the next cycle out_valid=1, out_data=8'hA5, out_break=0, level=1. Hold for 5 cycles: outputs stable. Assert out_ready for 1 cycle -> out_valid=0, level=0.
2. Push 8'h01..8'h10 (16 bytes, DEPTH=16) with out_ready=0 -> level=16, overflow=0. Push 8'h11 -> overflow=1, level=16. Drain -> reads 8'h01..8'h10 in order and 8'h11 never appears. Pulse clear_overflow -> overflow=0.
3. Fill to level=16, then in the same cycle push 8'h77 and pop -> level stays 16, overflow=0. After draining, 8'h77 is the last byte.
4. Push in_break=1 with in_data=8'h3C -> out_break=1, out_data=8'h00. Next push 8'h3C -> after the pop, out_break=0, out_data=8'h3C.
5. Push 3 bytes, then flush together with in_valid(8'h55) -> level=0, out_valid=0, overflow=0. The next push 8'h66 reads back as 8'h66. Repeat 40 push/pop pairs to exercise pointer wrap.
6. Deassert resetn mid-stream at level=5 with overflow=1 -> all outputs reset asynchronously. With UART_RX_FIFO_ALMOST_FULL_EN defined: almost_full=1 exactly from level 14.
